// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
// Holds the ALU opcode encoding, the response error codes, the issuer FSM
// state encoding and the internal operation classes used to decide how a
// response is formed.
package alu_pkg;

    localparam logic [3:0] OP_SGT   = 4'd0;
    localparam logic [3:0] OP_SLT   = 4'd1;
    localparam logic [3:0] OP_SLTU  = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_SGE   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_MAX   = 4'd9;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    // How the response of the in-flight operation is assembled.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_SUB,
        CLS_DIV0,
        CLS_ILL
    } opClass_t;

    function automatic logic isCompare(input logic [3:0] op);
        return (op == OP_SGT) || (op == OP_SLT) || (op == OP_SLTU) || (op == OP_SGE);
    endfunction

endpackage

// File: rtl/alu_cmp_unit.sv
// Combinational compare evaluator.
// Ports:
//   opcode_i - compare opcode (SGT, SLT, SGE signed; SLTU unsigned)
//   a_i, b_i - operands
//   result_o - 1 when the comparison holds, 0 otherwise (0 for non-compare ops)
module alu_cmp_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             result_o
);

    always_comb begin
        result_o = 1'b0;
        case (opcode_i)
            OP_SGT:  result_o = $signed(a_i) >  $signed(b_i);
            OP_SLT:  result_o = $signed(a_i) <  $signed(b_i);
            OP_SGE:  result_o = $signed(a_i) >= $signed(b_i);
            OP_SLTU: result_o = a_i < b_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Sequential front-end for the 64-bit combinational ALU.
// Accepts one request per req_valid/req_ready handshake, registers the
// operands onto the ALU inputs, waits SETTLE_CYCLES, then returns a tagged
// response on the rsp_valid/rsp_ready channel. One transaction in flight.
// Ports:
//   clk, rst_n                 - clock and synchronous active-low reset
//   req_*                      - request channel (opcode, operands, shift, tag)
//   alu_opcode/input1/input2/shiftValue - registered drive to the ALU
//   alu_result, alu_carryFlag  - ALU outputs
//   rsp_*                      - response channel (result, carry, tag, err)
//   busy                       - high whenever the issuer is not idle
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SHAMT_W       = 5,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_opcode,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHAMT_W-1:0] alu_shiftValue,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryFlag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [1:0]         rsp_err,
    output logic               busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    opClass_t           opClass_q, opClass_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [3:0]         aluOpcode_q, aluOpcode_d;
    logic [WIDTH-1:0]   aluInput1_q, aluInput1_d;
    logic [WIDTH-1:0]   aluInput2_q, aluInput2_d;
    logic [SHAMT_W-1:0] aluShift_q, aluShift_d;
    logic               rspValid_q, rspValid_d;
    logic [WIDTH-1:0]   rspResult_q, rspResult_d;
    logic               rspCarry_q, rspCarry_d;
    logic [TAG_W-1:0]   rspTag_q, rspTag_d;
    logic [1:0]         rspErr_q, rspErr_d;
    logic               busy_q, busy_d;
    logic               cmpResult;

    // Compares are evaluated on the operands already latched onto the ALU
    // inputs, so the result is stable for the whole settle window.
    alu_cmp_unit #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .opcode_i(aluOpcode_q),
        .a_i     (aluInput1_q),
        .b_i     (aluInput2_q),
        .result_o(cmpResult)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opClass_q   <= CLS_ALU;
            cnt_q       <= '0;
            tag_q       <= '0;
            aluOpcode_q <= '0;
            aluInput1_q <= '0;
            aluInput2_q <= '0;
            aluShift_q  <= '0;
            rspValid_q  <= 1'b0;
            rspResult_q <= '0;
            rspCarry_q  <= 1'b0;
            rspTag_q    <= '0;
            rspErr_q    <= ERR_OK;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opClass_q   <= opClass_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            aluOpcode_q <= aluOpcode_d;
            aluInput1_q <= aluInput1_d;
            aluInput2_q <= aluInput2_d;
            aluShift_q  <= aluShift_d;
            rspValid_q  <= rspValid_d;
            rspResult_q <= rspResult_d;
            rspCarry_q  <= rspCarry_d;
            rspTag_q    <= rspTag_d;
            rspErr_q    <= rspErr_d;
            busy_q      <= busy_d;
        end
    end

    // Illegal opcodes leave the ALU inputs untouched and pass through a
    // single settle cycle (cnt=0), so their response appears one edge after
    // acceptance.
    always_comb begin
        state_d     = state_q;
        opClass_d   = opClass_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        aluOpcode_d = aluOpcode_q;
        aluInput1_d = aluInput1_q;
        aluInput2_d = aluInput2_q;
        aluShift_d  = aluShift_q;
        rspValid_d  = rspValid_q;
        rspResult_d = rspResult_q;
        rspCarry_d  = rspCarry_q;
        rspTag_d    = rspTag_q;
        rspErr_d    = rspErr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tag_d   = req_tag;
                    state_d = ST_SETTLE;
                    if (req_opcode > OP_MAX) begin
                        opClass_d = CLS_ILL;
                        cnt_d     = '0;
                    end else begin
                        aluOpcode_d = req_opcode;
                        aluInput1_d = req_a;
                        aluInput2_d = req_b;
                        aluShift_d  = req_shamt;
                        cnt_d       = SETTLE_LOAD;
                        if (isCompare(req_opcode))
                            opClass_d = CLS_CMP;
                        else if (req_opcode == OP_SUB)
                            opClass_d = CLS_SUB;
                        else if (req_opcode == OP_DIV && req_b == '0)
                            opClass_d = CLS_DIV0;
                        else
                            opClass_d = CLS_ALU;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    rspValid_d  = 1'b1;
                    rspTag_d    = tag_q;
                    rspResult_d = alu_result;
                    rspCarry_d  = 1'b0;
                    rspErr_d    = ERR_OK;
                    state_d     = ST_RESP;
                    case (opClass_q)
                        CLS_ILL: begin
                            rspResult_d = '0;
                            rspErr_d    = ERR_ILLEGAL;
                        end
                        CLS_CMP:  rspResult_d = {{(WIDTH-1){1'b0}}, cmpResult};
                        CLS_SUB:  rspCarry_d  = alu_carryFlag;
                        CLS_DIV0: rspErr_d    = ERR_DIV0;
                        default:  rspResult_d = alu_result;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign alu_opcode     = aluOpcode_q;
    assign alu_input1     = aluInput1_q;
    assign alu_input2     = aluInput2_q;
    assign alu_shiftValue = aluShift_q;
    assign rsp_valid      = rspValid_q;
    assign rsp_result     = rspResult_q;
    assign rsp_carry      = rspCarry_q;
    assign rsp_tag        = rspTag_q;
    assign rsp_err        = rspErr_q;
    assign busy           = busy_q;

endmodule
